axis_rr_packet_arbiter: RTL and testbench
=========================================

Name: axis_rr_packet_arbiter

Overview:
- Shares one AXI-Stream master port between N_SRC AXI-Stream slave sources, e.g. several SHA3 core output transmitters feeding one downstream sink.
- Round-robin arbitration at packet granularity: a grant is held from the first beat until the TLAST beat is accepted.
- Tags each forwarded beat with the index of the winning source on m_tid.
- Sits between the per-core stream transmitters and the shared stream consumer.

Parameters:
- N_SRC, 4, number of slave sources, 2..2**ID_WIDTH.
- DATA_WIDTH, 64, TDATA width in bits, multiple of 8.
- USER_WIDTH, 4, TUSER width.
- ID_WIDTH, 2, m_tid width; must hold the source index.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, synchronous, active-low
- s_tvalid  in  N_SRC  per-source TVALID
- s_tready  out  N_SRC  per-source TREADY
- s_tdata  in  N_SRC*DATA_WIDTH  flattened TDATA, source i at [i*DATA_WIDTH +: DATA_WIDTH]
- s_tkeep  in  N_SRC*DATA_WIDTH/8  flattened TKEEP
- s_tuser  in  N_SRC*USER_WIDTH  flattened TUSER
- s_tlast  in  N_SRC  per-source TLAST
- m_tvalid  out  1  master TVALID
- m_tready  in  1  master TREADY
- m_tdata  out  DATA_WIDTH  muxed TDATA
- m_tkeep  out  DATA_WIDTH/8  muxed TKEEP
- m_tuser  out  USER_WIDTH  muxed TUSER
- m_tlast  out  1  muxed TLAST
- m_tid  out  ID_WIDTH  index of the granted source
- busy  out  1  high while a packet is granted

Behaviour:
- Registers:
  - state: IDLE or PASS.
  - grant: ID_WIDTH bits.
  - last_grant: ID_WIDTH bits.
- Reset (ARESETn=0 at a clock edge):
  - state=IDLE, grant=0, last_grant=N_SRC-1, so source 0 has highest priority after reset.
- Output values:
  - In IDLE: m_tvalid=0, s_tready=0 on all sources, busy=0, m_tid=grant.
  - In IDLE, m_tdata/m_tkeep/m_tuser/m_tlast are driven from source grant; they are don't-care while m_tvalid=0.
- In PASS (combinational mux on grant):
  - m_tvalid = s_tvalid[grant]; m_tdata/m_tkeep/m_tuser/m_tlast = source grant fields.
  - s_tready[grant] = m_tready; all other s_tready = 0.
  - busy=1, m_tid=grant.
  - No storage and no added latency on the data path.
- IDLE -> PASS:
  - Taken when any s_tvalid is high.
  - grant = first index with s_tvalid=1, scanning last_grant+1, last_grant+2, ... modulo N_SRC.
  - The arbitration cycle forwards no beat, so the first beat of a packet leaves at the earliest one cycle after its TVALID is seen.
- PASS -> IDLE:
  - Taken on the edge where m_tvalid & m_tready & m_tlast are all 1.
  - last_grant <= grant at the same edge.
  - There is always at least one IDLE cycle between packets; peak throughput is L/(L+1) beats per cycle for L-beat packets.
- PASS hold:
  - The grant never changes mid-packet, even if s_tvalid[grant] drops (bubble) or other sources assert TVALID.
  - m_tvalid follows the granted source's bubble.
- Non-granted sources see s_tready=0 and must hold their data per AXI-Stream rules.
- Single-beat packet (TLAST on first beat): PASS lasts exactly the cycles until handshake, then IDLE.
- A source that deasserts TVALID before it is granted is skipped; no request latching.
- Reset mid-packet:
  - Next cycle is IDLE with m_tvalid=0 and the grant dropped.
  - The partial packet is abandoned; downstream is responsible for framing recovery.
- Index wrap: with N_SRC not a power of two, the scan wraps at N_SRC; indices >= N_SRC are never granted.

Optional Feature:
- Macro: AXIS_ARB_PKT_CNT_EN.
- Defined:
  - Adds output pkt_cnt, N_SRC*16 bits, flattened per source.
  - Counter i increments by 1 on each accepted TLAST beat from source i.
  - Wraps 0xFFFF -> 0x0000.
  - Reset to 0 by ARESETn.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- Reset, no requests -> m_tvalid=0, busy=0, all s_tready=0, m_tid=0 for 10 cycles.
- Sources 0,1,2,3 each hold a 3-beat packet (data 0xA0..,0xB0..,0xC0..,0xD0..), m_tready=1 -> packets out in order 0,1,2,3, m_tid 0,1,2,3, 4 cycles per packet, no interleaving.
- After source 2 wins, sources 0 and 3 both request -> source 3 granted next (round-robin from last_grant=2).
- Source 1 drops TVALID for 2 cycles mid-packet while source 0 requests -> m_tvalid=0 for those 2 cycles, grant stays 1, source 0 s_tready=0 until source 1's TLAST is accepted.
- m_tready toggled 1010... during a 4-beat packet -> all 4 beats delivered once, in order, TLAST only on beat 4.
- ARESETn pulsed low on beat 2 of a 5-beat packet -> m_tvalid=0 next cycle; the next grant goes to source 0 if it requests.
- With AXIS_ARB_PKT_CNT_EN defined: 3 packets from source 1, 1 packet from source 2 -> pkt_cnt[1]=3, pkt_cnt[2]=1, others 0.

Source files
------------

// File: rtl/axis_rr_packet_arbiter.sv
// rtl/axis_rr_packet_arbiter.sv - packet-granular round-robin arbiter sharing one AXI-Stream master port
// Optional per-source accepted-packet counters are enabled by defining AXIS_ARB_PKT_CNT_EN.
module axis_rr_packet_arbiter #(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic [N_SRC-1:0]               s_tvalid,
    output logic [N_SRC-1:0]               s_tready,
    input  logic [N_SRC*DATA_WIDTH-1:0]    s_tdata,
    input  logic [N_SRC*DATA_WIDTH/8-1:0]  s_tkeep,
    input  logic [N_SRC*USER_WIDTH-1:0]    s_tuser,
    input  logic [N_SRC-1:0]               s_tlast,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [DATA_WIDTH-1:0]          m_tdata,
    output logic [DATA_WIDTH/8-1:0]        m_tkeep,
    output logic [USER_WIDTH-1:0]          m_tuser,
    output logic                           m_tlast,
    output logic [ID_WIDTH-1:0]            m_tid,
`ifdef AXIS_ARB_PKT_CNT_EN
    output logic [N_SRC*16-1:0]            pkt_cnt,
`endif
    output logic                           busy
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] grant_q, grant_d;
    logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;

    logic                sel_valid;
    logic                last_acc;
    logic                hit_hi, hit_lo;
    logic [ID_WIDTH-1:0] idx_hi, idx_lo;

    // Two-window scan: sources above last_grant first, then wrap to 0..last_grant.
    // Descending loop so the lowest matching index in each window wins.
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (s_tvalid[i]) begin
                if (i > int'(last_grant_q)) begin
                    hit_hi = 1'b1;
                    idx_hi = ID_WIDTH'(i);
                end else begin
                    hit_lo = 1'b1;
                    idx_lo = ID_WIDTH'(i);
                end
            end
        end
    end

    // Data path is a pure mux on grant; no storage, no added latency.
    always_comb begin
        m_tdata   = s_tdata[DATA_WIDTH-1:0];
        m_tkeep   = s_tkeep[KEEP_WIDTH-1:0];
        m_tuser   = s_tuser[USER_WIDTH-1:0];
        m_tlast   = s_tlast[0];
        sel_valid = s_tvalid[0];
        s_tready  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
                m_tdata   = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                m_tkeep   = s_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                m_tuser   = s_tuser[i*USER_WIDTH +: USER_WIDTH];
                m_tlast   = s_tlast[i];
                sel_valid = s_tvalid[i];
                if (state_q == PASS) begin
                    s_tready[i] = m_tready;
                end
            end
        end
        m_tvalid = (state_q == PASS) && sel_valid;
        busy     = (state_q == PASS);
        m_tid    = grant_q;
        last_acc = m_tvalid && m_tready && m_tlast;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (hit_hi || hit_lo) begin
                    state_d = PASS;
                    grant_d = hit_hi ? idx_hi : idx_lo;
                end
            end
            PASS: begin
                if (last_acc) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_WIDTH'(N_SRC - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef AXIS_ARB_PKT_CNT_EN
    logic [N_SRC*16-1:0] pkt_cnt_q, pkt_cnt_d;

    // 16-bit counters wrap naturally at 0xFFFF.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (last_acc && (grant_q == ID_WIDTH'(i))) begin
                pkt_cnt_d[i*16 +: 16] = pkt_cnt_q[i*16 +: 16] + 16'd1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// tb/tb_axis_rr_packet_arbiter.sv - scoreboard bench for axis_rr_packet_arbiter
// Source queues drive the slaves; a negedge monitor pops expected beats from a scoreboard queue.
module tb_axis_rr_packet_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int UW = 4;
    localparam int IW = 2;

    logic              ACLK;
    logic              ARESETn;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tready;
    logic [N*DW-1:0]   s_tdata;
    logic [N*KW-1:0]   s_tkeep;
    logic [N*UW-1:0]   s_tuser;
    logic [N-1:0]      s_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [UW-1:0]     m_tuser;
    logic              m_tlast;
    logic [IW-1:0]     m_tid;
    logic              busy;
`ifdef AXIS_ARB_PKT_CNT_EN
    logic [N*16-1:0]   pkt_cnt;
`endif

    axis_rr_packet_arbiter #(
        .N_SRC(N), .DATA_WIDTH(DW), .USER_WIDTH(UW), .ID_WIDTH(IW)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tlast(m_tlast),
        .m_tid(m_tid),
`ifdef AXIS_ARB_PKT_CNT_EN
        .pkt_cnt(pkt_cnt),
`endif
        .busy(busy)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [3:0]  user;
        logic        last;
        logic [7:0]  gap;
    } beat_t;

    beat_t        srcq [N][$];
    logic [78:0]  expq [$];
    int           tlast_cyc [$];
    logic [N-1:0] src_hs = '0;
    bit           loaded [N];
    int           wait_cnt [N];
    bit           tready_toggle = 1'b0;
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial forever begin
        @(posedge ACLK);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=time_expired exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mk_data(int src, int scen, int b);
        return {16'hD00D, 8'(scen), 8'(src), 16'h0000, 8'(8'hA0 + src * 16), 8'(b)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic load_pkt(input int src, input int scen, input int nb, input int gap_at, input int gap_len);
        beat_t bt;
        for (int b = 0; b < nb; b++) begin
            bt.data = mk_data(src, scen, b);
            bt.keep = (b == nb - 1) ? 8'h0F : 8'hFF;
            bt.user = 4'(b);
            bt.last = (b == nb - 1);
            bt.gap  = (b == gap_at) ? 8'(gap_len) : 8'd0;
            srcq[src].push_back(bt);
        end
    endtask

    task automatic exp_beats(input int src, input int scen, input int nb, input int from, input int to);
        for (int b = from; b <= to; b++) begin
            expq.push_back({2'(src), mk_data(src, scen, b),
                            (b == nb - 1) ? 8'h0F : 8'hFF, 4'(b), (b == nb - 1)});
        end
    endtask

    function automatic bit all_empty();
        bit e;
        e = (expq.size() == 0) && !busy;
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge ACLK);
            done = all_empty();
        end
        chk(name, {63'd0, done}, 64'd1);
    endtask

    task automatic wait_busy(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge ACLK);
            seen = busy;
        end
        chk(name, {63'd0, seen}, 64'd1);
    endtask

    task automatic step();
        @(posedge ACLK);
        #2;
    endtask

    // Source/sink driver: retire beats handshaken in the previous cycle, then present next heads.
    initial begin
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        for (int i = 0; i < N; i++) begin
            loaded[i]   = 1'b0;
            wait_cnt[i] = 0;
        end
        forever begin
            @(posedge ACLK);
            #1;
            for (int i = 0; i < N; i++) begin
                if (src_hs[i] && srcq[i].size() > 0) begin
                    srcq[i].delete(0);
                    loaded[i] = 1'b0;
                end
                if (!loaded[i] && srcq[i].size() > 0) begin
                    loaded[i]   = 1'b1;
                    wait_cnt[i] = int'(srcq[i][0].gap);
                end
                if (loaded[i] && wait_cnt[i] > 0) begin
                    wait_cnt[i]--;
                    s_tvalid[i] = 1'b0;
                end else if (loaded[i]) begin
                    s_tvalid[i]            = 1'b1;
                    s_tdata[i*DW +: DW]    = srcq[i][0].data;
                    s_tkeep[i*KW +: KW]    = srcq[i][0].keep;
                    s_tuser[i*UW +: UW]    = srcq[i][0].user;
                    s_tlast[i]             = srcq[i][0].last;
                end else begin
                    s_tvalid[i] = 1'b0;
                end
            end
            m_tready = tready_toggle ? ~m_tready : 1'b1;
        end
    end

    // Monitor: every master handshake is checked against the scoreboard head.
    initial begin
        logic [78:0] act;
        logic [78:0] e;
        forever begin
            @(negedge ACLK);
            src_hs = s_tvalid & s_tready;
            if (m_tvalid && m_tready) begin
                act = {m_tid, m_tdata, m_tkeep, m_tuser, m_tlast};
                if (m_tlast) tlast_cyc.push_back(cyc);
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++;
                    $display("FAIL beat_unexpected act=%h exp=none", act);
                end else begin
                    e = expq.pop_front();
                    if (act !== e) begin
                        n_bad++;
                        $display("FAIL beat act=%h exp=%h", act, e);
                    end
                end
            end
        end
    end

    initial begin
        int lows;
        bool_loop: begin end
        ARESETn = 1'b0;
        repeat (3) step();
        ARESETn = 1'b1;

        // Reset state with no requests.
        for (int k = 0; k < 10; k++) begin
            @(negedge ACLK);
            chk("reset_idle", {56'd0, m_tvalid, busy, s_tready, m_tid}, 64'd0);
        end

        // Four simultaneous 3-beat packets leave in index order, L+1 cycles apart.
        step();
        tlast_cyc.delete();
        for (int s = 0; s < N; s++) begin
            load_pkt(s, 2, 3, -1, 0);
            exp_beats(s, 2, 3, 0, 2);
        end
        wait_drain("s2_drain");
        chk("s2_tlast_count", 64'(tlast_cyc.size()), 64'd4);
        for (int k = 1; k < tlast_cyc.size(); k++) begin
            chk("s2_pkt_spacing", 64'(tlast_cyc[k] - tlast_cyc[k-1]), 64'd4);
        end

        // After source 2 wins, sources 0 and 3 contend: 3 is next in rotation.
        step();
        load_pkt(2, 3, 2, -1, 0);
        exp_beats(2, 3, 2, 0, 1);
        wait_busy("s3_busy");
        load_pkt(0, 3, 2, -1, 0);
        load_pkt(3, 3, 2, -1, 0);
        exp_beats(3, 3, 2, 0, 1);
        exp_beats(0, 3, 2, 0, 1);
        wait_drain("s3_drain");

        // Mid-packet bubble on source 1 while source 0 waits.
        step();
        load_pkt(1, 4, 4, 2, 2);
        load_pkt(0, 4, 2, -1, 0);
        exp_beats(1, 4, 4, 0, 3);
        exp_beats(0, 4, 2, 0, 1);
        wait_busy("s4_busy");
        lows = 0;
        for (int k = 0; k < 40 && busy; k++) begin
            chk("s4_hold", {61'd0, s_tready[0], m_tid}, {61'd0, 1'b0, 2'd1});
            if (!m_tvalid) lows++;
            @(negedge ACLK);
        end
        chk("s4_bubble_cycles", 64'(lows), 64'd2);
        wait_drain("s4_drain");

        // Toggling m_tready across a 4-beat packet.
        step();
        tready_toggle = 1'b1;
        load_pkt(2, 5, 4, -1, 0);
        exp_beats(2, 5, 4, 0, 3);
        wait_drain("s5_drain");
        tready_toggle = 1'b0;

        // Reset while beat 2 of a 5-beat packet is on the bus.
        step();
        step();
        load_pkt(3, 6, 5, -1, 0);
        exp_beats(3, 6, 5, 0, 1);
        begin
            bit hit;
            hit = 1'b0;
            for (int k = 0; k < 50 && !hit; k++) begin
                step();
                hit = (srcq[3].size() == 4);
            end
            chk("s6_reach_beat2", {63'd0, hit}, 64'd1);
        end
        ARESETn = 1'b0;
        load_pkt(0, 6, 2, -1, 0);
        exp_beats(0, 6, 2, 0, 1);
        exp_beats(3, 6, 5, 2, 4);
        step();
        ARESETn = 1'b1;
        chk("s6_after_reset", {62'd0, m_tvalid, busy}, 64'd0);
        wait_drain("s6_drain");

`ifdef AXIS_ARB_PKT_CNT_EN
        // Packet counters from a clean reset.
        step();
        ARESETn = 1'b0;
        step();
        step();
        ARESETn = 1'b1;
        chk("s7_cnt_reset", pkt_cnt, 64'd0);
        load_pkt(1, 7, 2, -1, 0);
        load_pkt(1, 8, 3, -1, 0);
        load_pkt(1, 9, 1, -1, 0);
        load_pkt(2, 10, 2, -1, 0);
        exp_beats(1, 7, 2, 0, 1);
        exp_beats(2, 10, 2, 0, 1);
        exp_beats(1, 8, 3, 0, 2);
        exp_beats(1, 9, 1, 0, 0);
        wait_drain("s7_drain");
        chk("s7_pkt_cnt", pkt_cnt, {16'd0, 16'd1, 16'd3, 16'd0});
`endif

        repeat (3) step();
        chk("final_scoreboard_empty", 64'(expq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
